// File: rtl/mul_limb_pkg.sv
// rtl/mul_limb_pkg.sv - shared types, defaults and limb helper for the limb-serial multiplier
package mul_limb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL_LIMB_W_DEF = 16;
    localparam int MUL_LIMBS_DEF  = 2;

    // limb_sel works on a fixed-width carrier; callers zero-extend in and truncate out
    localparam int MUL_VEC_MAX  = 1024;
    localparam int MUL_LIMB_MAX = 64;

    function automatic logic [MUL_LIMB_MAX-1:0] limb_sel(
        input logic [MUL_VEC_MAX-1:0] vec,
        input int                     k,
        input int                     width
    );
        logic [MUL_VEC_MAX-1:0] shifted;
        shifted = vec >> (k * width);
        return shifted[MUL_LIMB_MAX-1:0] & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/mul_limb_pp.sv
// rtl/mul_limb_pp.sv - combinational LIMB_W x LIMB_W unsigned partial-product unit
module mul_limb_pp #(
    parameter int LIMB_W = 16
) (
    input  logic [LIMB_W-1:0]   i_a,
    input  logic [LIMB_W-1:0]   i_b,
    output logic [2*LIMB_W-1:0] o_p
);

    logic [2*LIMB_W-1:0] w_a_ext;
    logic [2*LIMB_W-1:0] w_b_ext;

    assign w_a_ext = {{LIMB_W{1'b0}}, i_a};
    assign w_b_ext = {{LIMB_W{1'b0}}, i_b};
    assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/mul_limb_seq.sv
// rtl/mul_limb_seq.sv - limb-serial unsigned multiplier; optional MUL_LIMB_ZERO_BYPASS_EN skips MAC for zero operands
module mul_limb_seq
    import mul_limb_pkg::*;
#(
    parameter int LIMB_W = MUL_LIMB_W_DEF,
    parameter int LIMBS  = MUL_LIMBS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LIMBS*LIMB_W-1:0]   a,
    input  logic [LIMBS*LIMB_W-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*LIMBS*LIMB_W-1:0] y
);

    localparam int OP_W  = LIMBS * LIMB_W;
    localparam int ACC_W = 2 * OP_W;
    localparam int CW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_y;
    logic [CW-1:0]     r_i;
    logic [CW-1:0]     r_j;

    logic [LIMB_W-1:0]   w_a_limb;
    logic [LIMB_W-1:0]   w_b_limb;
    logic [2*LIMB_W-1:0] w_pp;
    logic [ACC_W-1:0]    w_pp_ext;
    logic [31:0]         w_shift;
    logic [ACC_W-1:0]    w_acc_sum;
    logic                w_last;
    logic                w_accept;
    logic                w_bypass;

    assign w_a_limb = LIMB_W'(limb_sel(MUL_VEC_MAX'(r_a), int'(r_i), LIMB_W));
    assign w_b_limb = LIMB_W'(limb_sel(MUL_VEC_MAX'(r_b), int'(r_j), LIMB_W));

    mul_limb_pp #(
        .LIMB_W (LIMB_W)
    ) u_pp (
        .i_a (w_a_limb),
        .i_b (w_b_limb),
        .o_p (w_pp)
    );

    assign w_pp_ext  = ACC_W'(w_pp);
    assign w_shift   = (32'(r_i) + 32'(r_j)) * LIMB_W;
    assign w_acc_sum = r_acc + (w_pp_ext << w_shift);
    assign w_last    = (r_i == LAST) && (r_j == LAST);
    assign w_accept  = in_valid && in_ready;

`ifdef MUL_LIMB_ZERO_BYPASS_EN
    assign w_bypass = (a == '0) || (b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_bypass ? DONE : MAC;
                end
            end
            MAC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Schoolbook walk: j is the inner limb index, i the outer one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_y   <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                        if (w_bypass) begin
                            r_y <= '0;
                        end
                    end
                end
                MAC: begin
                    r_acc <= w_acc_sum;
                    if (w_last) begin
                        r_y <= w_acc_sum;
                        r_i <= '0;
                        r_j <= '0;
                    end else if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_limb_seq.sv
// tb/tb_mul_limb_seq.sv - directed and parameter-sweep bench for mul_limb_seq
module tb_mul_limb_seq;

`ifdef MUL_LIMB_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_sw_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;

    int n_tests = 0;
    int n_fail  = 0;
    bit sw_done [3];

    always #5 clk = ~clk;

    mul_limb_seq #(
        .LIMB_W (16),
        .LIMBS  (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [63:0] ey, input int el);
        int cnt;
        bit rdy_seen;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1));
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt      = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cnt < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 128'(cnt + 1), 128'(el));
        check({tag, "_in_ready_busy"}, 128'(rdy_seen | in_ready), 128'(0));
        check({tag, "_y"}, 128'(y), 128'(ey));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 128'(out_valid), 128'(0));
        check({tag, "_ready_after_hs"}, 128'(in_ready), 128'(1));
    endtask

    // Parameter sweep: independent instances, driven concurrently with random stalls
    genvar g;
    for (g = 0; g < 3; g++) begin : g_sweep
        localparam int LW = (g == 2) ? 16 : 8;
        localparam int LN = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
        localparam int OW = LW * LN;

        logic            s_iv;
        logic            s_ir;
        logic            s_ov;
        logic            s_or;
        logic [OW-1:0]   s_a;
        logic [OW-1:0]   s_b;
        logic [2*OW-1:0] s_y;

        mul_limb_seq #(
            .LIMB_W (LW),
            .LIMBS  (LN)
        ) u_sw (
            .clk       (clk),
            .rst_n     (rst_sw_n),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .a         (s_a),
            .b         (s_b),
            .out_valid (s_ov),
            .out_ready (s_or),
            .y         (s_y)
        );

        initial begin
            logic [63:0]  ra;
            logic [63:0]  rb;
            logic [127:0] ey;
            int           cnt;
            int           el;
            s_iv = 1'b0;
            s_or = 1'b0;
            s_a  = '0;
            s_b  = '0;
            @(posedge rst_sw_n);
            for (int n = 0; n < 1000; n++) begin
                @(negedge clk);
                ra   = {$urandom(), $urandom()};
                rb   = {$urandom(), $urandom()};
                s_a  = ra[OW-1:0];
                s_b  = rb[OW-1:0];
                s_iv = 1'b1;
                ey   = 128'(s_a) * 128'(s_b);
                el   = LN * LN + 1;
`ifdef MUL_LIMB_ZERO_BYPASS_EN
                if (s_a == '0 || s_b == '0) el = 1;
`endif
                @(negedge clk);
                s_iv = 1'b0;
                cnt  = 0;
                while (!s_ov && cnt < 100) begin
                    @(negedge clk);
                    cnt++;
                end
                check($sformatf("sw%0d_latency", g), 128'(cnt + 1), 128'(el));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("sw%0d_y", g), 128'(s_y), ey);
                s_or = 1'b1;
                @(negedge clk);
                s_or = 1'b0;
            end
            sw_done[g] = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        rst_n     = 1'b0;
        rst_sw_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_y", 128'(y), 128'(0));
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;

        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
        run_op("basic", 32'h0001_2345, 32'h0000_0002, 64'h0000_0000_0002_468A, 5);
        run_op("b2b", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5);
        run_op("carry", 32'h0001_FFFF, 32'h0003_0001, 64'h0000_0005_FFFE_FFFF, 5);

        // Backpressure: stall in DONE with competing operand pulses
        @(negedge clk);
        a = 32'd3;
        b = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("bp_latency", 128'(wait_cnt + 1), 128'(5));
        for (int k = 0; k < 3; k++) begin
            a = 32'h0000_0100 + 32'(k);
            b = 32'h0000_0007;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_y_hold", 128'(y), 128'(15));
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 128'(out_valid), 128'(0));
        check("bp_release_ready", 128'(in_ready), 128'(1));
        check("bp_idle_y_hold", 128'(y), 128'(15));

        // Reset asserted two cycles after the accept edge
        a = 32'hFFFF_FFFF;
        b = 32'h1234_5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_y", 128'(y), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 5);

        run_op("zero", 32'h0000_0000, 32'h0000_1234, 64'h0, ZLAT);

        wait_cnt = 0;
        while (!(sw_done[0] && sw_done[1] && sw_done[2]) && wait_cnt < 60000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("sweep_complete", 128'(sw_done[0] && sw_done[1] && sw_done[2]), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
